rand_syndrome_gen: RTL
======================

// Module: rand_syndrome_gen
// PURPOSE
// - Pseudo-random error-syndrome source that feeds the root hub in the random-error regression
//   setup; it sits directly upstream of root_hub's syndrome input.
// - On each new_round_start it draws one Bernoulli bit per PU from a 32-bit LFSR.
// - It packs the PU_COUNT bits into OUT_WIDTH-bit words and streams them over a valid/ready
//   interface, then reports the syndrome count for the round.
// PARAMETERS
// - CODE_DISTANCE_X    5             X code distance
// - CODE_DISTANCE_Z    4             Z code distance
// - MEASUREMENT_ROUNDS max(DX,DZ)    rounds per decode
// - OUT_WIDTH          64            bits per output word, 1..64
// - SEED               32'hACE1_2024 LFSR reset/reload value; must be nonzero
// - derived: PU_COUNT = DX*DZ*ROUNDS; WORDS = ceil(PU_COUNT/OUT_WIDTH)
// PORTS
// - clk             in   1          single clock
// - reset           in   1          synchronous, active-low (one clock; reset is synchronous and active-low)
// - new_round_start in   1          one-cycle pulse requesting a round
// - error_threshold in   16         error probability = threshold/65536, sampled at accepted start
// - out_data        out  OUT_WIDTH  packed syndrome word
// - out_valid       out  1          word valid
// - out_ready       in   1          consumer accepts word
// - busy            out  1          round in progress
// - round_done      out  1          one-cycle pulse after the last word handshake
// - syndrome_count  out  32         number of 1 bits in the last completed round
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - state IDLE; lfsr<=SEED; all outputs 0; a round in flight is abandoned with no done pulse.
// - LFSR: Galois, 32-bit, taps 32'h8020_0003, shifted right by one step per GEN cycle.
//   - Bit drawn = (lfsr[15:0] < thr_q), using the pre-step value.
//   - thr=0 yields all zeros. The LFSR state persists across rounds; it is not reseeded on start.
// - Bit n = INDEX(i,j,k) = i*DZ + j + k*DZ*DX.
//   - Bit n maps to word n/OUT_WIDTH, bit n%OUT_WIDTH.
//   - Bit n is drawn before bit n+1. Padding bits of the final word are 0.
// - FSM:
//   - IDLE: new_round_start=1 -> latch thr_q, clear bit_cnt and pop count, go to GEN.
//     start is ignored in all other states; busy=1 outside IDLE.
//   - GEN: one bit per cycle into the word register. After OUT_WIDTH bits, or the final PU bit,
//     go to SEND.
//   - SEND: out_valid=1, out_data held stable until out_ready.
//     On handshake: if bits remain, go to GEN with the word register cleared.
//     Otherwise go to DONE.
//   - DONE: one cycle. round_done=1, syndrome_count updated in the same cycle. Next state IDLE.
// - Latency, ready held 1:
//   - Start sampled at edge t -> first out_valid high in the cycle after edge t+OUT_WIDTH.
//   - Total round = PU_COUNT + WORDS + 1 cycles after the start edge.
// - Backpressure: no LFSR advance while in SEND.
// - out_valid never drops without a handshake.
// - The pop count counts raw drawn bits and saturates at 32'hFFFF_FFFF. Saturation cannot be
//   reached for legal sizes.
// CONFIGURATION
// - RAND_SYNDROME_EVEN_PARITY_EN defined:
//   - The final PU bit (n=PU_COUNT-1) is replaced by the parity of bits 0..PU_COUNT-2, so each
//     round carries an even number of syndromes.
//   - syndrome_count reflects the forced bit.
//   - The LFSR still steps once for that bit.
// - Undefined: the final bit is drawn like any other; the count may be odd.
// TESTING
// - Common setup: DX=DZ=ROUNDS=3, OUT_WIDTH=8, so PU_COUNT=27 and WORDS=4.
// - T1 thr=0, ready=1:
//   - Start -> 4 words of 8'h00, the last with padding bits 7..3 = 0.
//   - round_done 32 cycles after start; syndrome_count=0.
// - T2 thr=16'hFFFF: every bit with lfsr[15:0]!=16'hFFFF is 1.
//   - Compare against a bench reference model of the LFSR from SEED.
//   - Words must match exactly and syndrome_count must equal the model count.
// - T3 backpressure: ready low 5 cycles per word.
//   - out_data is stable while valid && !ready.
//   - Word sequence is identical to T2; no LFSR advance during stalls.
// - T4 start pulse during GEN and during SEND -> ignored.
//   - Exactly one round_done; next round starts only after IDLE.
// - T5 reset low mid-SEND of word 2:
//   - Outputs 0 next cycle and no round_done.
//   - A restarted round reproduces T2's first word (LFSR reset to SEED).
// - T6 with RAND_SYNDROME_EVEN_PARITY_EN and thr=16'h4000, 50 rounds:
//   - Every syndrome_count is even.
//   - Bit 26 equals the XOR of bits 0..25.

Source files
------------

// File: rtl/rand_syndrome_gen_if.sv
// rand_syndrome_gen_if: start/threshold request, packed-word stream and round status bundle.
interface rand_syndrome_gen_if #(
    parameter int OUT_WIDTH = 64
);
    logic                 new_round_start;
    logic [15:0]          error_threshold;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 round_done;
    logic [31:0]          syndrome_count;
    modport master (
        input  new_round_start, error_threshold, out_ready,
        output out_data, out_valid, busy, round_done, syndrome_count
    );
    modport slave (
        output new_round_start, error_threshold, out_ready,
        input  out_data, out_valid, busy, round_done, syndrome_count
    );
endinterface

// File: rtl/rand_syndrome_gen.sv
// rand_syndrome_gen: LFSR-driven Bernoulli syndrome source streamed as packed words.
// Define RAND_SYNDROME_EVEN_PARITY_EN to force the final bit so every round has even weight.
module rand_syndrome_gen #(
    parameter int          CODE_DISTANCE_X    = 5,
    parameter int          CODE_DISTANCE_Z    = 4,
    parameter int          MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
    parameter int          OUT_WIDTH          = 64,
    parameter logic [31:0] SEED               = 32'hACE1_2024
) (
    input logic                 clk,
    input logic                 reset,
    rand_syndrome_gen_if.master bus
);
    localparam int PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS;
    localparam int CW = $clog2(PU_COUNT + 1);
    localparam int PW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(PU_COUNT - 1);
    localparam logic [CW-1:0] ALL_BITS = CW'(PU_COUNT);
    localparam logic [PW-1:0] LAST_POS = PW'(OUT_WIDTH - 1);
    localparam logic [31:0]   TAPS     = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, GEN, SEND, DONE} state_t;

    state_t               state, state_d;
    logic [31:0]          lfsr, pop, count;
    logic [15:0]          thr;
    logic [CW-1:0]        bit_cnt;
    logic [PW-1:0]        pos;
    logic [OUT_WIDTH-1:0] word;
    logic                 parity, drawn, draw, last_bit, word_full, start;

    assign start     = state == IDLE && bus.new_round_start;
    assign last_bit  = bit_cnt == LAST_BIT;
    assign word_full = pos == LAST_POS;
    assign drawn     = lfsr[15:0] < thr;
`ifdef RAND_SYNDROME_EVEN_PARITY_EN
    assign draw = last_bit ? parity : drawn;
`else
    assign draw = drawn;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = bus.new_round_start ? GEN : IDLE;
            GEN:     state_d = (word_full || last_bit) ? SEND : GEN;
            SEND:    state_d = !bus.out_ready ? SEND : (bit_cnt == ALL_BITS) ? DONE : GEN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            lfsr    <= SEED;
            pop     <= '0;
            count   <= '0;
            thr     <= '0;
            bit_cnt <= '0;
            pos     <= '0;
            word    <= '0;
            parity  <= 1'b0;
        end else begin
            state <= state_d;
            if (start) begin
                thr     <= bus.error_threshold;
                bit_cnt <= '0;
                pos     <= '0;
                pop     <= '0;
                parity  <= 1'b0;
                word    <= '0;
            end
            // The LFSR only steps while drawing, so stalls in SEND never consume randomness.
            if (state == GEN) begin
                lfsr       <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
                word[pos]  <= draw;
                pos        <= (word_full || last_bit) ? '0 : pos + 1'b1;
                bit_cnt    <= bit_cnt + 1'b1;
                pop        <= pop + 32'(draw && pop != '1);
                parity     <= parity ^ draw;
            end
            if (state == SEND && bus.out_ready) begin
                word <= '0;
                if (bit_cnt == ALL_BITS)
                    count <= pop;
            end
        end
    end

    assign bus.out_data       = word;
    assign bus.out_valid      = state == SEND;
    assign bus.busy           = state != IDLE;
    assign bus.round_done     = state == DONE;
    assign bus.syndrome_count = count;
endmodule
